// File: rtl/mul_pipe.sv
// mul_pipe: parametrised multi-cycle signed multiply pipeline for the
// execute stage. It sits beside the ALU and feeds the writeback mux.
//
// An operand pair enters stage 1 when in_valid && !stall && !flush. The
// full 2*WIDTH signed product is formed before stage 1. Only the low WIDTH
// bits are kept, together with zero/overflow flags computed once at entry.
// The flags then travel unchanged through STAGES registered stages. The
// final stage drives the outputs directly.
//
// Parameters:
//   WIDTH   operand/result width (>= 2)
//   STAGES  pipeline depth = latency in cycles (>= 1)
//   DST_W   destination register index width
//
// Ports:
//   clk, rst_n        rising-edge clock, asynchronous active-low reset
//   in_valid          operand pair present
//   in_a, in_b        signed operands
//   in_dst            destination register index
//   stall             hold every stage register
//   flush             kill all in-flight operations (wins over stall)
//   src_a, src_b      source indices of the instruction in decode
//   in_ready          operation will be accepted this cycle (= !stall)
//   out_valid         final stage holds a live result
//   result            low WIDTH bits of the product
//   zero              result == 0
//   overflow          signed product does not fit in WIDTH bits
//   dst               destination of result
//   hazard            a live in-flight non-zero dst matches src_a/src_b
//   occupancy         number of live stages

module mul_pipe #(
    parameter int WIDTH  = 32,
    parameter int STAGES = 5,
    parameter int DST_W  = 5,
    localparam int OCC_W = $clog2(STAGES + 1)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    input  logic [WIDTH-1:0] in_a,
    input  logic [WIDTH-1:0] in_b,
    input  logic [DST_W-1:0] in_dst,
    input  logic             stall,
    input  logic             flush,
    input  logic [DST_W-1:0] src_a,
    input  logic [DST_W-1:0] src_b,
    output logic             in_ready,
    output logic             out_valid,
    output logic [WIDTH-1:0] result,
    output logic             zero,
    output logic             overflow,
    output logic [DST_W-1:0] dst,
    output logic             hazard,
    output logic [OCC_W-1:0] occupancy
);

    // Index 0 is stage 1 and index STAGES-1 is the final stage.
    logic [STAGES-1:0] valid_q;
    logic [STAGES-1:0] zero_q;
    logic [STAGES-1:0] ovf_q;
    logic [WIDTH-1:0]  res_q [STAGES];
    logic [DST_W-1:0]  dst_q [STAGES];

    // Both operands are sign-extended to 2*WIDTH so that the multiply
    // yields the exact signed product in its low 2*WIDTH bits.
    logic signed [2*WIDTH-1:0] a_ext;
    logic signed [2*WIDTH-1:0] b_ext;
    logic signed [2*WIDTH-1:0] product;
    logic [WIDTH:0]            prod_hi;
    logic [WIDTH-1:0]          prod_lo;
    logic                      new_zero;
    logic                      new_ovf;

    assign a_ext   = $signed({{WIDTH{in_a[WIDTH-1]}}, in_a});
    assign b_ext   = $signed({{WIDTH{in_b[WIDTH-1]}}, in_b});
    assign product = a_ext * b_ext;
    assign prod_lo = product[WIDTH-1:0];
    assign prod_hi = product[2*WIDTH-1:WIDTH-1];

    // The product fits in WIDTH signed bits only when everything from the
    // result's sign bit upward is a copy of that sign bit.
    assign new_ovf  = !((&prod_hi) || !(|prod_hi));
    assign new_zero = (prod_lo == '0);

    // Valid bits and payload share one register process.
    // Flush clears only the valid bits. Payload is free to hold stale data
    // because nothing downstream looks at it without a valid bit.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q <= '0;
            zero_q  <= '0;
            ovf_q   <= '0;
            for (int k = 0; k < STAGES; k++) begin
                res_q[k] <= '0;
                dst_q[k] <= '0;
            end
        end else begin
            if (flush) begin
                valid_q <= '0;
            end else if (!stall) begin
                valid_q[0] <= in_valid;
                for (int k = 1; k < STAGES; k++) begin
                    valid_q[k] <= valid_q[k-1];
                end
            end

            if (!stall) begin
                res_q[0]  <= prod_lo;
                zero_q[0] <= new_zero;
                ovf_q[0]  <= new_ovf;
                dst_q[0]  <= in_dst;
                for (int k = 1; k < STAGES; k++) begin
                    res_q[k]  <= res_q[k-1];
                    zero_q[k] <= zero_q[k-1];
                    ovf_q[k]  <= ovf_q[k-1];
                    dst_q[k]  <= dst_q[k-1];
                end
            end
        end
    end

    assign in_ready  = !stall;
    assign out_valid = valid_q[STAGES-1];
    assign result    = res_q[STAGES-1];
    assign zero      = zero_q[STAGES-1];
    assign overflow  = ovf_q[STAGES-1];
    assign dst       = dst_q[STAGES-1];

    // Register 0 is the hard-wired zero register.
    // A write to register 0 can never create a dependency.
    always_comb begin
        hazard = 1'b0;
        for (int k = 0; k < STAGES; k++) begin
            if (valid_q[k] && (dst_q[k] != '0) &&
                ((dst_q[k] == src_a) || (dst_q[k] == src_b))) begin
                hazard = 1'b1;
            end
        end
    end

    // Population count of the live stages.
    always_comb begin
        occupancy = '0;
        for (int k = 0; k < STAGES; k++) begin
            occupancy = occupancy + OCC_W'(valid_q[k]);
        end
    end

endmodule

// File: tb/tb_mul_pipe.sv
// tb_mul_pipe: scoreboard bench for mul_pipe (WIDTH=32, STAGES=5, DST_W=5).
// When the pipeline accepts an operation, a reference result is pushed onto
// a queue. The reference is built from 64-bit integer arithmetic.
// A negedge monitor compares every presented output against the head of the
// queue. It also checks in_ready, occupancy and hazard against the queue
// contents.
// Each queued entry carries the "advance count" at which it must appear.
// The advance count increments on every non-stalled clock edge, which lets
// the monitor check latency including any stall cycles.

module tb_mul_pipe;

    localparam int WIDTH  = 32;
    localparam int STAGES = 5;
    localparam int DST_W  = 5;
    localparam int OCC_W  = $clog2(STAGES + 1);
    localparam longint MAXV = 64'sh0000_0000_7FFF_FFFF;
    localparam longint MINV = -MAXV - 1;

    typedef struct {
        logic [WIDTH-1:0] result;
        logic             zero;
        logic             ovf;
        logic [DST_W-1:0] dst;
        int               due;
    } exp_t;

    logic             clk;
    logic             rst_n;
    logic             in_valid;
    logic [WIDTH-1:0] in_a;
    logic [WIDTH-1:0] in_b;
    logic [DST_W-1:0] in_dst;
    logic             stall;
    logic             flush;
    logic [DST_W-1:0] src_a;
    logic [DST_W-1:0] src_b;
    logic             in_ready;
    logic             out_valid;
    logic [WIDTH-1:0] result;
    logic             zero;
    logic             overflow;
    logic [DST_W-1:0] dst;
    logic             hazard;
    logic [OCC_W-1:0] occupancy;

    exp_t sb_q[$];
    int   act_count;
    int   n_compared;
    int   n_mismatch;

    mul_pipe #(.WIDTH(WIDTH), .STAGES(STAGES), .DST_W(DST_W)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .in_valid (in_valid),
        .in_a     (in_a),
        .in_b     (in_b),
        .in_dst   (in_dst),
        .stall    (stall),
        .flush    (flush),
        .src_a    (src_a),
        .src_b    (src_b),
        .in_ready (in_ready),
        .out_valid(out_valid),
        .result   (result),
        .zero     (zero),
        .overflow (overflow),
        .dst      (dst),
        .hazard   (hazard),
        .occupancy(occupancy)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Reference product: exact signed 64-bit multiply, then range check.
    function automatic exp_t modelOp(input logic [WIDTH-1:0] a,
                                     input logic [WIDTH-1:0] b,
                                     input logic [DST_W-1:0] d,
                                     input int due);
        exp_t   e;
        longint pa;
        longint pb;
        longint p;
        pa = longint'($signed(a));
        pb = longint'($signed(b));
        p  = pa * pb;
        e.result = p[WIDTH-1:0];
        e.zero   = (e.result == 0);
        e.ovf    = (p > MAXV) || (p < MINV);
        e.dst    = d;
        e.due    = due;
        return e;
    endfunction

    // A hazard exists if any in-flight op with a non-zero dst matches a source.
    function automatic logic modelHazard(input logic [DST_W-1:0] sa,
                                         input logic [DST_W-1:0] sb);
        logic h;
        h = 1'b0;
        for (int i = 0; i < sb_q.size(); i++) begin
            if (sb_q[i].dst != 0 && (sb_q[i].dst == sa || sb_q[i].dst == sb))
                h = 1'b1;
        end
        return h;
    endfunction

    task automatic checkOutput(input string name, input longint actual,
                               input longint expected);
        n_compared++;
        if (actual != expected) begin
            n_mismatch++;
            $display("[TB] FAIL %s: got %0h, expected %0h at %0t",
                     name, actual, expected, $time);
        end
    endtask

    task automatic applyStimulus(input logic v, input logic [WIDTH-1:0] a,
                                 input logic [WIDTH-1:0] b,
                                 input logic [DST_W-1:0] d,
                                 input logic st, input logic fl,
                                 input logic [DST_W-1:0] sa,
                                 input logic [DST_W-1:0] sb);
        in_valid = v;
        in_a     = a;
        in_b     = b;
        in_dst   = d;
        stall    = st;
        flush    = fl;
        src_a    = sa;
        src_b    = sb;
        @(posedge clk);
        #1;
    endtask

    task automatic idleCycles(input int n, input logic [DST_W-1:0] sa,
                              input logic [DST_W-1:0] sb);
        for (int i = 0; i < n; i++)
            applyStimulus(1'b0, '0, '0, '0, 1'b0, 1'b0, sa, sb);
    endtask

    // Model side of the scoreboard: track accepts, flushes and advances.
    always @(posedge clk) begin
        if (rst_n) begin
            if (!stall) act_count <= act_count + 1;
            if (flush) begin
                sb_q.delete();
            end else if (!stall && in_valid) begin
                sb_q.push_back(modelOp(in_a, in_b, in_dst,
                                       act_count + 1 + STAGES - 1));
            end
        end
    end

    always @(negedge rst_n) sb_q.delete();

    // Monitor: compare everything the DUT presents, away from the edge.
    always @(negedge clk) begin
        logic exp_valid;
        if (!rst_n) begin
            checkOutput("reset out_valid", out_valid, 0);
            checkOutput("reset result", result, 0);
            checkOutput("reset zero", zero, 0);
            checkOutput("reset overflow", overflow, 0);
            checkOutput("reset dst", dst, 0);
            checkOutput("reset hazard", hazard, 0);
            checkOutput("reset occupancy", occupancy, 0);
            checkOutput("reset in_ready", in_ready, !stall);
        end else begin
            checkOutput("in_ready", in_ready, !stall);
            checkOutput("occupancy", occupancy, sb_q.size());
            checkOutput("hazard", hazard, modelHazard(src_a, src_b));
            exp_valid = (sb_q.size() > 0) && (sb_q[0].due == act_count);
            checkOutput("out_valid", out_valid, exp_valid);
            if (out_valid && exp_valid) begin
                checkOutput("result", result, sb_q[0].result);
                checkOutput("zero", zero, sb_q[0].zero);
                checkOutput("overflow", overflow, sb_q[0].ovf);
                checkOutput("dst", dst, sb_q[0].dst);
                if (!stall && !flush) void'(sb_q.pop_front());
            end
        end
    end

    initial begin
        int drain;
        n_compared = 0;
        n_mismatch = 0;
        act_count  = 0;
        rst_n      = 1'b0;
        in_valid   = 1'b0;
        in_a       = '0;
        in_b       = '0;
        in_dst     = '0;
        stall      = 1'b0;
        flush      = 1'b0;
        src_a      = '0;
        src_b      = '0;
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b1;

        $display("[TB] single op 6*7");
        applyStimulus(1'b1, 6, 7, 3, 1'b0, 1'b0, 0, 0);
        idleCycles(7, 0, 0);

        $display("[TB] back-to-back ops");
        applyStimulus(1'b1, 32'h0001_0000, 32'h0001_0000, 4, 1'b0, 1'b0, 0, 0);
        applyStimulus(1'b1, 32'hFFFF_FFFF, 1, 5, 1'b0, 1'b0, 0, 0);
        applyStimulus(1'b1, 0, 123, 6, 1'b0, 1'b0, 0, 0);
        idleCycles(7, 0, 0);

        $display("[TB] stall with blocked offer");
        applyStimulus(1'b1, 32'hFFFF_FFFD, 11, 7, 1'b0, 1'b0, 0, 0);
        idleCycles(2, 0, 0);
        applyStimulus(1'b0, 0, 0, 0, 1'b1, 1'b0, 0, 0);
        applyStimulus(1'b1, 5, 5, 9, 1'b1, 1'b0, 0, 0);
        applyStimulus(1'b0, 0, 0, 0, 1'b1, 1'b0, 0, 0);
        applyStimulus(1'b0, 0, 0, 0, 1'b1, 1'b0, 0, 0);
        idleCycles(8, 0, 0);

        $display("[TB] hazard on dst 8, none on dst 0");
        applyStimulus(1'b1, 3, 5, 8, 1'b0, 1'b0, 8, 0);
        idleCycles(7, 8, 0);
        applyStimulus(1'b1, 2, 2, 0, 1'b0, 1'b0, 0, 0);
        idleCycles(7, 0, 0);

        $display("[TB] flush together with stall");
        applyStimulus(1'b1, 100, 200, 1, 1'b0, 1'b0, 0, 0);
        applyStimulus(1'b1, 300, 400, 2, 1'b0, 1'b0, 0, 0);
        applyStimulus(1'b1, 500, 600, 3, 1'b0, 1'b0, 1, 2);
        applyStimulus(1'b1, 9, 9, 9, 1'b1, 1'b1, 1, 2);
        idleCycles(7, 1, 2);

        $display("[TB] async reset mid-pipeline");
        applyStimulus(1'b1, 12, 12, 10, 1'b0, 1'b0, 10, 0);
        applyStimulus(1'b1, 13, 13, 11, 1'b0, 1'b0, 10, 0);
        in_valid = 1'b0;
        #3;
        rst_n = 1'b0;
        #1;
        checkOutput("async out_valid", out_valid, 0);
        checkOutput("async occupancy", occupancy, 0);
        checkOutput("async hazard", hazard, 0);
        checkOutput("async result", result, 0);
        @(posedge clk);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        idleCycles(8, 10, 11);

        $display("[TB] randomized traffic");
        for (int i = 0; i < 400; i++) begin
            logic [WIDTH-1:0] a;
            logic [WIDTH-1:0] b;
            case ($urandom_range(0, 3))
                0: begin
                    a = WIDTH'($urandom_range(0, 200)) - 100;
                    b = WIDTH'($urandom_range(0, 200)) - 100;
                end
                1: begin
                    a = $urandom;
                    b = $urandom;
                end
                2: begin
                    a = 32'h8000_0000;
                    b = ($urandom_range(0, 1) == 1) ? 32'hFFFF_FFFF : 1;
                end
                default: begin
                    a = $urandom_range(0, 65535);
                    b = $urandom_range(0, 65535);
                end
            endcase
            applyStimulus($urandom_range(0, 9) < 7, a, b,
                          DST_W'($urandom_range(0, 31)),
                          $urandom_range(0, 9) < 2,
                          $urandom_range(0, 24) == 0,
                          DST_W'($urandom_range(0, 31)),
                          DST_W'($urandom_range(0, 31)));
        end

        drain = 0;
        while (sb_q.size() > 0 && drain < 40) begin
            idleCycles(1, 0, 0);
            drain++;
        end
        checkOutput("drain remaining", sb_q.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_compared, n_mismatch);
        $finish;
    end

endmodule

// File: doc/mul_pipe.md
# mul_pipe

Parametrised multi-cycle multiply pipeline for the execute stage, generalising the fixed five-stage multiply chain into a configurable number of registered stages. It accepts a signed operand pair with a destination register, produces the low `WIDTH` bits of the product with zero and overflow flags after `STAGES` cycles, and supports stall, flush and hazard reporting. It sits beside the ALU in the execute stage and feeds the writeback mux.

## Interface

Parameters:
- `WIDTH`, 32, operand/result width in bits (≥ 2)
- `STAGES`, 5, pipeline depth = latency in cycles (≥ 1)
- `DST_W`, 5, destination register index width

Ports:
- `clk`  in  1  clock, rising-edge
- `rst_n`  in  1  asynchronous, active-low reset
- `in_valid`  in  1  operand pair present
- `in_a`  in  `WIDTH`  signed operand A
- `in_b`  in  `WIDTH`  signed operand B
- `in_dst`  in  `DST_W`  destination register index
- `stall`  in  1  hold entire pipeline
- `flush`  in  1  kill all in-flight operations
- `src_a`, `src_b`  in  `DST_W` each  source register indices of the instruction in decode
- `in_ready`  out  1  operation will be accepted this cycle
- `out_valid`  out  1  result valid at final stage
- `result`  out  `WIDTH`  low `WIDTH` bits of product
- `zero`  out  1  `result == 0`
- `overflow`  out  1  signed product does not fit in `WIDTH` bits
- `dst`  out  `DST_W`  destination of `result`
- `hazard`  out  1  `src_a` or `src_b` matches a non-zero in-flight `dst`
- `occupancy`  out  `$clog2(STAGES+1)`  number of valid stages

## Operation

- Stage k (1..`STAGES`) holds `valid[k]`, product low half, `zero`, `overflow`, `dst`.
- Accept: `in_ready = !stall`; an operation enters stage 1 on an edge where `in_valid && in_ready && !flush`.
- Product: full 2·`WIDTH` signed product formed before stage 1; `result` = bits [`WIDTH`-1:0]; `overflow` = 1 iff bits [2·`WIDTH`-1:`WIDTH`-1] are not all equal. Flags computed once, carried unchanged.
- Advance: when `!stall`, each stage k+1 loads stage k; stage 1 loads the new op or `valid=0`. Final stage drives outputs directly (registered, no combinational path from inputs).
- Stall: all stage registers hold; outputs unchanged; an `out_valid` result stays presented for every stalled cycle (consumer must not double-count; writeback is idempotent).
- Flush: on the edge, all `valid[k]` cleared; payload registers may keep stale data. Flush overrides stall and in_valid.
- Hazard: combinational OR over k of `valid[k] && dst[k] != 0 && (dst[k]==src_a || dst[k]==src_b)`. Register 0 never raises a hazard.
- `occupancy` = popcount of `valid[1..STAGES]`, combinational.
- Pipeline is never full in a blocking sense: every non-stalled cycle retires the final stage.

## Timing

- Reset (async, `rst_n`=0): all `valid` = 0, `result` = 0, `zero` = 0, `overflow` = 0, `dst` = 0, `out_valid` = 0; hence `hazard` = 0, `occupancy` = 0, `in_ready` = `!stall`.
- Reset mid-operation discards all in-flight ops; first accept after release edge proceeds normally.
- Latency: op accepted at edge t appears with `out_valid`=1 after edge t+`STAGES`-1 (i.e. during cycle t+`STAGES`), plus one cycle per stalled edge in between.
- Throughput: one op per cycle when not stalled.
- Simultaneous stall and flush: flush wins; pipeline empty next cycle.
- `STAGES`=1: single register, latency 1, hazard covers that stage only.

## Test plan

- Reset then `in_a`=6, `in_b`=7, `in_dst`=3, one cycle, `STAGES`=5 -> `out_valid`=1 exactly 5 cycles later with `result`=42, `zero`=0, `overflow`=0, `dst`=3; all reset values checked before.
- Back-to-back: 0x10000 × 0x10000 (dst 4), then −1 × 1 (dst 5), then 0 × 123 (dst 6) -> consecutive cycles: result 0/`overflow`=1; 0xFFFFFFFF/`overflow`=0; 0/`zero`=1; `occupancy` peaks at 3.
- Stall: issue op (dst 7), assert `stall` 3 cycles after issue for 4 cycles -> result appears 9 cycles after issue, `in_ready`=0 during stall, an `in_valid` offered while stalled is not captured.
- Flush with stall: three ops in flight, assert `stall` and `flush` together -> next cycle `occupancy`=0, no `out_valid` for following 5 cycles.
- Hazard: op with dst 8 in flight, `src_a`=8 -> `hazard`=1 until it leaves final stage; op with dst 0 in flight and `src_b`=0 -> `hazard`=0.
- Async reset asserted mid-pipeline (two ops in flight, between edges) -> outputs zero immediately, no result emerges after release.
